// File: rtl/spi_sram_responder.sv
// SPI-slave SRAM stand-in: sequential READ (0x03), WRITE (0x02) and RDSR (0x05) over mode-0 SPI,
// served from an internal byte array with a backdoor load/inspect port.
module spi_sram_responder #(
  parameter int unsigned MEM_BYTES   = 256,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  STATUS_VAL  = 8'h40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        busy,
  output logic        cmd_err,
  input  logic        bd_we,
  input  logic [15:0] bd_addr,
  input  logic [7:0]  bd_wdata,
  output logic [7:0]  bd_rdata
);

  localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD,
    ST_WR,
    ST_STATUS,
    ST_IGNORE
  } state_t;

  logic [7:0] r_mem [0:MEM_BYTES-1];

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;

  state_t      r_state;
  logic [3:0]  r_bit_cnt;
  logic [6:0]  r_cmd_sh;
  logic [14:0] r_addr_sh;
  logic [6:0]  r_wdata_sh;
  logic [15:0] r_addr;
  logic [7:0]  r_tx_shift;
  logic        r_is_wr;
  logic        r_miso;
  logic        r_cmd_err;
  logic [7:0]  r_bd_rdata;

  logic          w_sclk;
  logic          w_cs_n;
  logic          w_mosi;
  logic          w_rise;
  logic          w_fall;
  logic [7:0]    w_cmd_byte;
  logic [15:0]   w_addr_next;
  logic [15:0]   w_addr_inc;
  logic [7:0]    w_wbyte;
  logic          w_spi_we;
  logic [AW-1:0] w_addr_idx;
  logic [AW-1:0] w_addr_next_idx;
  logic [AW-1:0] w_addr_inc_idx;
  logic [AW-1:0] w_bd_idx;
  logic          w_unused_bd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync[0] <= spi_sclk;
      r_cs_sync[0]   <= spi_cs_n;
      r_mosi_sync[0] <= spi_mosi;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sclk_sync[i] <= r_sclk_sync[i-1];
        r_cs_sync[i]   <= r_cs_sync[i-1];
        r_mosi_sync[i] <= r_mosi_sync[i-1];
      end
      r_sclk_d <= w_sclk;
    end
  end

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise = w_sclk & ~r_sclk_d;
  assign w_fall = ~w_sclk & r_sclk_d;

  assign w_cmd_byte      = {r_cmd_sh, w_mosi};
  assign w_addr_next     = {r_addr_sh, w_mosi};
  assign w_addr_inc      = r_addr + 16'd1;
  assign w_wbyte         = {r_wdata_sh, w_mosi};
  assign w_addr_idx      = r_addr[AW-1:0];
  assign w_addr_next_idx = w_addr_next[AW-1:0];
  assign w_addr_inc_idx  = w_addr_inc[AW-1:0];
  assign w_bd_idx        = bd_addr[AW-1:0];
  assign w_unused_bd     = ^bd_addr;

  assign w_spi_we = ~w_cs_n && (r_state == ST_WR) && w_rise && (r_bit_cnt == 4'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_cmd_sh   <= '0;
      r_addr_sh  <= '0;
      r_wdata_sh <= '0;
      r_addr     <= '0;
      r_tx_shift <= '0;
      r_is_wr    <= 1'b0;
      r_miso     <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      if (w_cs_n) begin
        r_state   <= ST_IDLE;
        r_miso    <= 1'b0;
        r_bit_cnt <= '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_state   <= ST_CMD;
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
          end
          ST_CMD: begin
            r_miso <= 1'b0;
            if (w_rise) begin
              r_cmd_sh <= w_cmd_byte[6:0];
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= '0;
                case (w_cmd_byte)
                  8'h03: begin
                    r_state <= ST_ADDR;
                    r_is_wr <= 1'b0;
                  end
                  8'h02: begin
                    r_state <= ST_ADDR;
                    r_is_wr <= 1'b1;
                  end
                  8'h05: begin
                    r_state    <= ST_STATUS;
                    r_tx_shift <= STATUS_VAL;
                  end
                  default: begin
                    r_state   <= ST_IGNORE;
                    r_cmd_err <= 1'b1;
                  end
                endcase
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          ST_ADDR: begin
            r_miso <= 1'b0;
            if (w_rise) begin
              r_addr_sh <= w_addr_next[14:0];
              if (r_bit_cnt == 4'd15) begin
                r_bit_cnt <= '0;
                r_addr    <= w_addr_next;
                if (r_is_wr) begin
                  r_state <= ST_WR;
                end else begin
                  r_state    <= ST_RD;
                  r_tx_shift <= r_mem[w_addr_next_idx];
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          ST_RD: begin
            if (w_fall) begin
              r_miso <= r_tx_shift[7];
              // The 8th fall drives the last bit and preloads the next byte in one step.
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt  <= '0;
                r_addr     <= w_addr_inc;
                r_tx_shift <= r_mem[w_addr_inc_idx];
              end else begin
                r_bit_cnt  <= r_bit_cnt + 4'd1;
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              end
            end
          end
          ST_WR: begin
            r_miso <= 1'b0;
            if (w_rise) begin
              r_wdata_sh <= w_wbyte[6:0];
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= '0;
                r_addr    <= w_addr_inc;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          ST_STATUS: begin
            if (w_fall) begin
              r_miso <= r_tx_shift[7];
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt  <= '0;
                r_tx_shift <= STATUS_VAL;
              end else begin
                r_bit_cnt  <= r_bit_cnt + 4'd1;
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              end
            end
          end
          ST_IGNORE: begin
            r_miso <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_miso  <= 1'b0;
          end
        endcase
      end
    end
  end

  // SPI write is issued last so it overrides a same-cycle backdoor write to the same byte.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      r_mem[w_bd_idx] <= bd_wdata;
    end
    if (w_spi_we) begin
      r_mem[w_addr_idx] <= w_wbyte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bd_rdata <= '0;
    end else begin
      r_bd_rdata <= r_mem[w_bd_idx];
    end
  end

  assign spi_miso = r_miso;
  assign busy     = (r_state != ST_IDLE);
  assign cmd_err  = r_cmd_err;
  assign bd_rdata = r_bd_rdata;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: backdoor access, SPI write/read, wrap, RDSR,
// unsupported command, partial write and mid-read reset.
module tb_spi_sram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_cs_n = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        busy;
  logic        cmd_err;
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [7:0]  bd_wdata = '0;
  logic [7:0]  bd_rdata;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;

  spi_sram_responder #(
    .MEM_BYTES  (256),
    .SYNC_STAGES(2),
    .STATUS_VAL (8'h40)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .spi_cs_n(spi_cs_n),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .busy    (busy),
    .cmd_err (cmd_err),
    .bd_we   (bd_we),
    .bd_addr (bd_addr),
    .bd_wdata(bd_wdata),
    .bd_rdata(bd_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_err) err_pulses <= err_pulses + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    bd_we    = 1'b1;
    bd_addr  = a;
    bd_wdata = d;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  task automatic bd_read(input logic [15:0] a, output logic [7:0] d);
    @(posedge clk);
    #1;
    bd_addr = a;
    @(posedge clk);
    #1;
    d = bd_rdata;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nb; i--) begin
      spi_mosi = tx[i];
      half();
      rx[i] = spi_miso;
      spi_sclk = 1'b1;
      half();
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    half();
  endtask

  task automatic cs_end();
    half();
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    half();
    half();
  endtask

  task automatic spi_read2(input logic [15:0] a, output logic [7:0] b0, output logic [7:0] b1);
    logic [7:0] rx;
    cs_begin();
    spi_bits(8'h03, 8, rx);
    spi_bits(a[15:8], 8, rx);
    spi_bits(a[7:0], 8, rx);
    spi_bits(8'h00, 8, b0);
    spi_bits(8'h00, 8, b1);
    cs_end();
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] b0;
    logic [7:0] b1;
    int base;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_miso", {15'd0, spi_miso}, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'h0000);
    chk("rst_cmd_err", {15'd0, cmd_err}, 16'h0000);
    chk("rst_bd_rdata", {8'd0, bd_rdata}, 16'h0000);
    reset = 1'b0;
    half();
    chk("idle_busy", {15'd0, busy}, 16'h0000);

    // Backdoor write then registered backdoor read.
    bd_write(16'h0010, 8'h5A);
    bd_read(16'h0010, rx);
    chk("bd_rd_0010", {8'd0, rx}, 16'h005A);

    // SPI WRITE 02 00 10 A5 3C.
    cs_begin();
    spi_bits(8'h02, 8, rx);
    chk("busy_in_cmd", {15'd0, busy}, 16'h0001);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h10, 8, rx);
    spi_bits(8'hA5, 8, rx);
    spi_bits(8'h3C, 8, rx);
    chk("wr_miso_zero", {15'd0, spi_miso}, 16'h0000);
    cs_end();
    chk("busy_after_cs", {15'd0, busy}, 16'h0000);
    bd_read(16'h0011, rx);
    chk("bd_rd_0011", {8'd0, rx}, 16'h003C);
    bd_read(16'h0010, rx);
    chk("bd_rd_0010_spi", {8'd0, rx}, 16'h00A5);

    spi_read2(16'h0010, b0, b1);
    chk("rd_0010_b0", {8'd0, b0}, 16'h00A5);
    chk("rd_0010_b1", {8'd0, b1}, 16'h003C);
    chk("rd_miso_idle", {15'd0, spi_miso}, 16'h0000);

    // Sequential wrap 0xFFFF -> 0x0000 through the modulo-256 alias.
    bd_write(16'h00FF, 8'h11);
    bd_write(16'h0000, 8'h22);
    bd_read(16'hFFFF, rx);
    chk("bd_alias_ffff", {8'd0, rx}, 16'h0011);
    spi_read2(16'hFFFF, b0, b1);
    chk("wrap_b0", {8'd0, b0}, 16'h0011);
    chk("wrap_b1", {8'd0, b1}, 16'h0022);

    // RDSR.
    cs_begin();
    spi_bits(8'h05, 8, rx);
    spi_bits(8'h00, 8, b0);
    spi_bits(8'h00, 8, b1);
    cs_end();
    chk("rdsr_b0", {8'd0, b0}, 16'h0040);
    chk("rdsr_b1", {8'd0, b1}, 16'h0040);

    // Unsupported command 0x9F.
    base = err_pulses;
    cs_begin();
    spi_bits(8'h9F, 8, rx);
    spi_bits(8'h00, 8, b0);
    spi_bits(8'h00, 8, b1);
    chk("ign_busy", {15'd0, busy}, 16'h0001);
    cs_end();
    chk("ign_err_pulses", 16'(err_pulses - base), 16'h0001);
    chk("ign_b0", {8'd0, b0}, 16'h0000);
    chk("ign_b1", {8'd0, b1}, 16'h0000);
    chk("ign_busy_end", {15'd0, busy}, 16'h0000);

    // Partial write byte must be discarded.
    bd_write(16'h0020, 8'h77);
    cs_begin();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h20, 8, rx);
    spi_bits(8'hFF, 4, rx);
    cs_end();
    spi_read2(16'h0020, b0, b1);
    chk("partial_spi_rd", {8'd0, b0}, 16'h0077);
    bd_read(16'h0020, rx);
    chk("partial_bd_rd", {8'd0, rx}, 16'h0077);

    // Reset during the RD data phase, while MISO carries bit 7 of 0xA5.
    cs_begin();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h10, 8, rx);
    half();
    chk("rd_bit7_high", {15'd0, spi_miso}, 16'h0001);
    chk("rd_busy", {15'd0, busy}, 16'h0001);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_miso", {15'd0, spi_miso}, 16'h0000);
    chk("async_rst_busy", {15'd0, busy}, 16'h0000);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    half();
    reset = 1'b0;
    half();
    spi_read2(16'h0010, b0, b1);
    chk("post_rst_b0", {8'd0, b0}, 16'h00A5);
    chk("post_rst_b1", {8'd0, b1}, 16'h003C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
